// File: rtl/uart_debug_loader.sv
// uart_debug_loader: serial program loader in front of the instruction ROM.
// Receives 8N1 bytes, parses a framed packet (sync, base address, word
// count, little-endian data words, XOR checksum) and writes each assembled
// word through a single-cycle ROM write port. busy_o holds the core while a
// packet is being received.
module uart_debug_loader #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_debug_pin,
  input  logic        uart_rx,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  logic            rx_s1_q;
  logic            rx_s2_q;
  logic            rx_prev_q;
  logic            start_edge;
  rx_state_e       rx_state_q;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  logic [7:0]      rx_byte_q;
  logic            rx_valid_q;
  logic            rx_ferr_q;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign start_edge = rx_prev_q & ~rx_s2_q;

  // Bit-timing FSM: mid-start check, 8 data samples, stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      if (!uart_debug_pin) begin
        rx_state_q <= RX_IDLE;
        rx_cnt_q   <= '0;
        rx_bit_q   <= '0;
      end else begin
        case (rx_state_q)
          RX_IDLE: begin
            if (start_edge) begin
              rx_state_q <= RX_START;
              rx_cnt_q   <= '0;
            end
          end
          RX_START: begin
            if (rx_cnt_q == HALF_LAST) begin
              rx_cnt_q   <= '0;
              rx_bit_q   <= '0;
              // A line that is high again at mid-start was a glitch.
              rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
            end else begin
              rx_cnt_q <= rx_cnt_q + 1'b1;
            end
          end
          RX_DATA: begin
            if (rx_cnt_q == DIV_LAST) begin
              rx_cnt_q   <= '0;
              rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
              rx_bit_q   <= rx_bit_q + 3'd1;
              if (rx_bit_q == 3'd7) begin
                rx_state_q <= RX_STOP;
              end
            end else begin
              rx_cnt_q <= rx_cnt_q + 1'b1;
            end
          end
          RX_STOP: begin
            if (rx_cnt_q == DIV_LAST) begin
              rx_cnt_q   <= '0;
              rx_state_q <= RX_IDLE;
              if (rx_s2_q) begin
                rx_valid_q <= 1'b1;
                rx_byte_q  <= rx_shift_q;
              end else begin
                rx_ferr_q <= 1'b1;
              end
            end else begin
              rx_cnt_q <= rx_cnt_q + 1'b1;
            end
          end
          default: rx_state_q <= RX_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Packet loader
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    L_IDLE,
    L_ADDR,
    L_CNT,
    L_DATA,
    L_CSUM
  } ld_state_e;

  ld_state_e   ld_state_q;
  logic [1:0]  byte_idx_q;
  logic [31:0] asm_q;
  logic [31:0] asm_d;
  logic [31:0] waddr_q;
  logic [15:0] remain_q;
  logic [7:0]  csum_q;
  logic [7:0]  csum_d;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  // Bytes enter at the top and move down, so after four bytes the first
  // received byte sits in bits 7:0 (little-endian assembly).
  assign asm_d  = {rx_byte_q, asm_q[31:8]};
  assign csum_d = csum_q ^ rx_byte_q;

  // Packet parser with registered write port and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state_q <= L_IDLE;
      byte_idx_q <= '0;
      asm_q      <= '0;
      waddr_q    <= '0;
      remain_q   <= '0;
      csum_q     <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      if (!uart_debug_pin) begin
        // Silent abort: no status pulse, written words are kept.
        ld_state_q <= L_IDLE;
        byte_idx_q <= '0;
        busy_q     <= 1'b0;
      end else if (rx_ferr_q && (ld_state_q != L_IDLE)) begin
        ld_state_q <= L_IDLE;
        byte_idx_q <= '0;
        busy_q     <= 1'b0;
        err_q      <= 1'b1;
      end else if (rx_valid_q) begin
        case (ld_state_q)
          L_IDLE: begin
            if (rx_byte_q == SYNC_BYTE) begin
              ld_state_q <= L_ADDR;
              byte_idx_q <= '0;
              csum_q     <= '0;
              busy_q     <= 1'b1;
            end
          end
          L_ADDR: begin
            asm_q      <= asm_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              waddr_q    <= asm_d;
              ld_state_q <= L_CNT;
            end
          end
          L_CNT: begin
            asm_q <= asm_d;
            if (byte_idx_q == 2'd1) begin
              byte_idx_q <= '0;
              remain_q   <= asm_d[31:16];
              ld_state_q <= (asm_d[31:16] == 16'd0) ? L_CSUM : L_DATA;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
          L_DATA: begin
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              mem_we_q   <= 1'b1;
              mem_addr_q <= waddr_q;
              mem_data_q <= asm_d;
              waddr_q    <= waddr_q + 32'd4;
              remain_q   <= remain_q - 16'd1;
              if (remain_q == 16'd1) begin
                ld_state_q <= L_CSUM;
              end
            end
          end
          L_CSUM: begin
            ld_state_q <= L_IDLE;
            busy_q     <= 1'b0;
            if (rx_byte_q == csum_q) begin
              done_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: ld_state_q <= L_IDLE;
        endcase
      end
    end
  end

  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
